// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program-counter register and next-PC selection for the
// RISC core. Chooses between increment, branch, jump, call/return, stall hold
// and halt, and drives instruction-memory fetch qualification.
//
// Optional build macro: PC_RAS_EN
//   defined   - a circular return-address stack of RAS_DEPTH entries is built;
//               call pushes pc+1, ret pops (empty pop loads RESET_PC and
//               pulses ras_err).
//   undefined - no RAS storage; call behaves as jump, ret is ignored and
//               ras_err stays 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold the PC (level)
//   halt, resume        enter / leave HALT
//   branch_taken/target conditional branch redirect
//   jump/jump_target    unconditional jump redirect
//   call, ret           subroutine call (to jump_target) / return
//   pc                  registered fetch address
//   fetch_valid         pc is fetched this cycle (state is RUN)
//   flush               first cycle pc holds a redirect target
//   halted              state is HALT
//   ras_err             one-cycle pulse on RAS underflow
module pc_sequencer #(
  parameter int          PC_W      = 11,
  parameter int unsigned RESET_PC  = 0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted,
  output logic            ras_err
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  // Legacy encodings kept so the state values stay unchanged.
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  typedef enum logic [1:0] {
    BOOT  = S_BOOT,
    RUN   = S_RUN,
    STALL = S_STALL,
    HALT  = S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic            ras_err_q, ras_err_d;

  logic [PC_W-1:0] pc_inc;
  logic            ras_push, ras_pop;
  logic            ret_en;
  logic            ras_avail;
  logic [PC_W-1:0] ras_top;

  assign pc_inc = pc_q + 1'b1;

`ifdef PC_RAS_EN
  localparam int SP_W = $clog2(RAS_DEPTH);
  localparam logic [SP_W:0] RAS_FULL = (SP_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PC_W-1:0] ras_d [RAS_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;     // next free slot; wraps, overwriting oldest
  logic [SP_W:0]   cnt_q, cnt_d;   // valid entries, saturates at RAS_DEPTH

  assign ret_en    = ret;
  assign ras_avail = (cnt_q != '0);
  assign ras_top   = ras_q[sp_q - 1'b1];

  always_comb begin
    ras_d = ras_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (ras_push) begin
      ras_d[sp_q] = pc_inc;
      sp_d        = sp_q + 1'b1;
      if (cnt_q != RAS_FULL) cnt_d = cnt_q + 1'b1;
    end else if (ras_pop) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_ras;

  assign ret_en     = 1'b0;
  assign ras_avail  = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ^{ret, ras_push, ras_pop};
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = 1'b0;
    ras_err_d = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    // Without the RAS, ret_en is 0 and call falls through to the jump path.
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, STALL: begin
        if (halt)       state_d = HALT;
        else if (stall) state_d = STALL;
        else            state_d = RUN;

        if (ret_en) begin
          flush_d = 1'b1;
          if (ras_avail) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d      = RST_PC;
            ras_err_d = 1'b1;
          end
        end else if (call) begin
          pc_d     = jump_target;
          flush_d  = 1'b1;
          ras_push = 1'b1;
        end else if (jump) begin
          pc_d    = jump_target;
          flush_d = 1'b1;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          flush_d = 1'b1;
        end else if (state_q == RUN && !stall && !halt) begin
          // Only advance past a pc that was actually fetched; leaving STALL
          // refetches the held pc.
          pc_d = pc_inc;
        end
      end
      HALT: if (resume) state_d = RUN;
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
    halted_d      = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RST_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      ras_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      ras_err_q     <= ras_err_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign halted      = halted_q;
  assign ras_err     = ras_err_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the RISC core. It owns the fetch PC register and selects each next PC from increment, branch, jump, call/return, stall hold or halt. It replaces the bare incrementer feeding instruction memory: decode and execute drive redirect requests, and instruction memory reads `pc` whenever `fetch_valid` is high.

## Interface
Parameters:
- `PC_W`, 11, PC width in bits; instruction-memory depth is 2^PC_W words.
- `RESET_PC`, 0, PC value loaded on reset.
- `RAS_DEPTH`, 4, number of return-address stack entries; power of two, minimum 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold the PC; level-sensitive.
- `halt`  in  1  enter HALT (single-cycle pulse from decode).
- `resume`  in  1  leave HALT.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  PC_W  branch destination.
- `jump`  in  1  unconditional jump.
- `jump_target`  in  PC_W  jump destination.
- `call`  in  1  subroutine call; destination is `jump_target`.
- `ret`  in  1  subroutine return.
- `pc`  out  PC_W  current fetch address (registered).
- `fetch_valid`  out  1  high when `pc` is to be fetched this cycle.
- `flush`  out  1  one-cycle pulse in the first cycle `pc` holds a redirect target.
- `halted`  out  1  high while in HALT.
- `ras_err`  out  1  one-cycle pulse on RAS underflow.

## Operation
- States: BOOT, RUN, STALL, HALT.
- Reset: `pc`=RESET_PC, state=BOOT, `fetch_valid`=0, `flush`=0, `halted`=0, `ras_err`=0, RAS empty.
- BOOT: always moves to RUN on the next edge; `pc` is unchanged.
- RUN and STALL choose the next state in this priority order:
  - `halt` -> HALT
  - `stall` -> STALL
  - otherwise -> RUN
- RUN and STALL choose the next PC in this priority order:
  - `ret` -> top of RAS, then pop
  - `call` -> `jump_target`, and push `pc`+1
  - `jump` -> `jump_target`
  - `branch_taken` -> `branch_target`
  - `stall` or `halt` -> hold `pc`
  - otherwise -> `pc`+1
- A redirect takes priority over `stall`: the target loads even when the next state is STALL.
- Increment is modulo 2^PC_W: 2047 -> 0 when PC_W=11. Wrap-around raises no flag.
- `push` is registered as `pc`+1, also modulo 2^PC_W.
- RAS full on `call`: the oldest entry is overwritten (circular buffer); no error.
- RAS empty on `ret`: `pc` loads RESET_PC and `ras_err` pulses.
- HALT: `pc` holds and all redirect, stall and call inputs are ignored. `resume` -> RUN, fetching the held `pc`. `halt` and `resume` together in HALT -> RUN.
- `fetch_valid` = (state==RUN), registered. `halted` = (state==HALT), registered.
- `rst` takes priority over everything in every state. The RAS contents are cleared.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- A redirect sampled at edge N: `pc`=target and `flush`=1 in cycle N+1. `flush` drops in N+2 unless another redirect is accepted.
- First fetch after reset release: rst low at edge N -> state BOOT in N+1 -> `fetch_valid`=1 with `pc`=RESET_PC in N+2.
- `stall` sampled at edge N: `fetch_valid`=0 in N+1. Deasserted at edge M: `fetch_valid`=1 in M+1 at the held or redirected `pc`.
- Push and pop complete at the same edge as the `pc` update; back-to-back call/ret in consecutive cycles is supported.

## Configuration
- `PC_RAS_EN` defined: the RAS is built and `call`/`ret` behave as specified above.
- `PC_RAS_EN` undefined: no RAS storage is built; the ports remain present.
  - `call` behaves exactly as `jump`.
  - `ret` is ignored.
  - `ras_err` is tied to 0.

## Test plan
- Reset boot: rst high for 2 cycles, then low -> `pc`=0 and `fetch_valid`=0 for one cycle, then `fetch_valid`=1 and `pc` counts 0,1,2,3.
- Wrap-around: jump to 2046, no further inputs -> `pc` sequence is 2046, 2047, 0, 1; `flush` is high only in the 2046 cycle.
- Redirect during stall: `stall`=1 at `pc`=5 with `branch_taken`=1 and target 40 in the same cycle -> `pc`=40, `flush`=1, `fetch_valid`=0. Release stall -> fetch 40, then 41.
- Halt and resume: `halt` at `pc`=9, then `jump` while halted -> `pc` stays 9 and `halted`=1. `resume` -> `fetch_valid`=1 at 9, then 10.
- RAS (`PC_RAS_EN` defined): call 100 at `pc`=10, then call 200 at `pc`=101 -> ret to 102, ret to 11. A third `ret` -> `pc`=0 and `ras_err` pulses for 1 cycle.
- RAS overflow: 5 calls issued from `pc`=1, 2, 3, 4, 5 with RAS_DEPTH=4 -> rets return to 6, 5, 4, 3; the next `ret` underflows.
